// File: rtl/alu_ctrl_md.sv
// ALU select decode for RV32I plus an iterative radix-2 RV32M multiply/divide sequencer.
// ALU_CTRL_DIV_EN enables the divide datapath; without it, divides finish in one stall cycle with result 0.
module alu_ctrl_md #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [2:0]      ALUOp_i,
  input  logic [6:0]      Funct7_i,
  input  logic [2:0]      Funct3_i,
  input  logic            opcode_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      ALUSignal_o,
  output logic            md_op_o,
  output logic [XLEN-1:0] md_result_o,
  output logic            md_done_o,
  output logic            stall_o
);

  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4,  ALU_MUL = 4'd5, ALU_XOR = 4'd6, ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8,  ALU_SRL = 4'd9, ALU_SLTU = 4'd10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              neg;
  logic [XLEN-1:0]   hi, lo, opnd;

  logic [XLEN-1:0]   nxt_hi, nxt_lo, step_res, fast_res;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod, prod_s;
  logic              s1, s2, neg_a, neg_b, fast, accept;

  // ---------------- decode ----------------
  function automatic logic [3:0] base_sel(input logic [2:0] f3);
    case (f3)
      3'b000:  base_sel = ALU_ADD;
      3'b001:  base_sel = ALU_SLL;
      3'b010:  base_sel = ALU_SLT;
      3'b011:  base_sel = ALU_SLTU;
      3'b100:  base_sel = ALU_XOR;
      3'b101:  base_sel = ALU_SRL;
      3'b110:  base_sel = ALU_OR;
      default: base_sel = ALU_AND;
    endcase
  endfunction

  always_comb begin
    ALUSignal_o = ALU_ADD;
    md_op_o     = 1'b0;
    case (ALUOp_i)
      3'b000: begin
        case (Funct7_i)
          7'b0000000: ALUSignal_o = base_sel(Funct3_i);
          7'b0100000: begin
            if (Funct3_i == 3'b000)      ALUSignal_o = ALU_SUB;
            else if (Funct3_i == 3'b101) ALUSignal_o = ALU_SRA;
          end
          7'b0000001: begin
            md_op_o     = 1'b1;
            ALUSignal_o = ALU_MUL;
          end
          default: ;
        endcase
      end
      3'b001: begin
        // Loads/stores/JALR (opcode_i=0) always compute an address with ADD.
        if (opcode_i) begin
          if (Funct3_i == 3'b101) ALUSignal_o = Funct7_i[5] ? ALU_SRA : ALU_SRL;
          else                    ALUSignal_o = base_sel(Funct3_i);
        end
      end
      default: ;
    endcase
  end

  // ---------------- operand preparation ----------------
  always_comb begin
    s1    = (Funct3_i == 3'b000) || (Funct3_i == 3'b001) || (Funct3_i == 3'b010) ||
            (Funct3_i == 3'b100) || (Funct3_i == 3'b110);
    s2    = (Funct3_i == 3'b000) || (Funct3_i == 3'b001) ||
            (Funct3_i == 3'b100) || (Funct3_i == 3'b110);
    neg_a = s1 & rs1_i[XLEN-1];
    neg_b = s2 & rs2_i[XLEN-1];
    a_mag = neg_a ? -rs1_i : rs1_i;
    b_mag = neg_b ? -rs2_i : rs2_i;
  end

`ifdef ALU_CTRL_DIV_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic div_zero, div_ovf;
  always_comb begin
    div_zero = (rs2_i == '0);
    div_ovf  = s1 & (rs1_i == INT_MIN) & (rs2_i == '1);
    fast     = Funct3_i[2] & (div_zero | div_ovf);
    if (div_zero) fast_res = Funct3_i[1] ? rs1_i : '1;
    else          fast_res = Funct3_i[1] ? '0 : rs1_i;
  end
`else
  always_comb begin
    fast     = Funct3_i[2];
    fast_res = '0;
  end
`endif

  assign accept  = (state == IDLE) & valid_i & md_op_o & ~flush_i;
  assign stall_o = rst_ni & (accept | (state == RUN));

  // ---------------- one iteration ----------------
  // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
`ifdef ALU_CTRL_DIV_EN
  logic [XLEN:0]   sh_rem, trial;
  logic [XLEN-1:0] quo_rem;
`endif

  always_comb begin
    nxt_hi  = hi;
    nxt_lo  = lo;
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
`ifdef ALU_CTRL_DIV_EN
    sh_rem  = {hi, lo[XLEN-1]};
    trial   = sh_rem - {1'b0, opnd};
    if (op[2]) begin
      if (!trial[XLEN]) begin
        nxt_hi = trial[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = sh_rem[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b0};
      end
    end else
`endif
    begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {nxt_hi, nxt_lo};
    prod_s   = neg ? -prod : prod;
    step_res = (op[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef ALU_CTRL_DIV_EN
    quo_rem  = op[1] ? nxt_hi : nxt_lo;
    if (op[2]) step_res = neg ? -quo_rem : quo_rem;
`endif
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      op          <= '0;
      neg         <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      md_result_o <= '0;
      md_done_o   <= 1'b0;
    end else begin
      md_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op  <= Funct3_i;
            // REM takes the dividend's sign; everything else the xor of both.
            neg <= (Funct3_i[2] & Funct3_i[1]) ? neg_a : (neg_a ^ neg_b);
            hi  <= '0;
            if (fast) begin
              state       <= DONE;
              md_result_o <= fast_res;
              md_done_o   <= 1'b1;
            end else begin
              state <= RUN;
              cnt   <= CNT_W'(XLEN);
              opnd  <= Funct3_i[2] ? b_mag : a_mag;
              lo    <= Funct3_i[2] ? a_mag : b_mag;
            end
          end
        end
        RUN: begin
          if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            hi  <= nxt_hi;
            lo  <= nxt_lo;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state       <= DONE;
              md_result_o <= step_res;
              md_done_o   <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Randomised bench for alu_ctrl_md against an arithmetic reference model (XLEN=32).
module tb_alu_ctrl_md;
  logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0, opcode = 1'b0;
  logic [2:0]  aluop = '0, f3 = '0;
  logic [6:0]  f7 = '0;
  logic [31:0] rs1 = '0, rs2 = '0, md_result;
  logic [3:0]  alu_sel;
  logic        md_op, md_done, stall;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_ctrl_md dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .flush_i(flush),
    .ALUOp_i(aluop), .Funct7_i(f7), .Funct3_i(f3), .opcode_i(opcode),
    .rs1_i(rs1), .rs2_i(rs2), .ALUSignal_o(alu_sel), .md_op_o(md_op),
    .md_result_o(md_result), .md_done_o(md_done), .stall_o(stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {md_op, select} straight from the instruction tables
  function automatic logic [4:0] dec_ref(input logic [2:0] op, input logic [6:0] fn7,
                                         input logic [2:0] fn3, input logic opc);
    logic [3:0] base;
    case (fn3)
      3'd0: base = 4'd0;  3'd1: base = 4'd7;  3'd2: base = 4'd4;  3'd3: base = 4'd10;
      3'd4: base = 4'd6;  3'd5: base = 4'd9;  3'd6: base = 4'd3;  default: base = 4'd2;
    endcase
    if (op == 3'b000 && fn7 == 7'h01) return {1'b1, 4'd5};
    if (op == 3'b000 && fn7 == 7'h00) return {1'b0, base};
    if (op == 3'b000 && fn7 == 7'h20)
      return {1'b0, (fn3 == 3'd0) ? 4'd1 : (fn3 == 3'd5) ? 4'd8 : 4'd0};
    if (op == 3'b001 && opc)
      return {1'b0, (fn3 == 3'd5) ? (fn7[5] ? 4'd8 : 4'd9) : base};
    return 5'd0;
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    longint unsigned pu;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
`ifndef ALU_CTRL_DIV_EN
    if (fn[2]) return 32'h0;
`endif
    case (fn)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = 64'(ua) * 64'(ub); return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int md_lat(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    if (!fn[2]) return 33;
`ifdef ALU_CTRL_DIV_EN
    if (b == 0) return 1;
    if ((fn == 3'd4 || fn == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom % 64;
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
  task automatic run_md(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    int el, lat, stalls;
    bit done;
    er = md_ref(fn, a, b);
    el = md_lat(fn, a, b);
    aluop = 3'b000; f7 = 7'h01; f3 = fn; rs1 = a; rs2 = b; flush = 1'b0; valid = 1'b1;
    #1;
    check("md_op", md_op, 1);
    check("md_sel", alu_sel, 5);
    check("accept_stall", stall, 1);
    stalls = 1; lat = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      lat++;
      if (md_done) done = 1;
      else if (stall) stalls++;
    end
    if (!done) check("md_timeout", 0, 1);
    else begin
      check($sformatf("md_res f3=%0d a=%0h b=%0h", fn, a, b), md_result, er);
      check("md_latency", lat, el);
      check("md_stall_cycles", stalls, el);
      check("done_stall", stall, 0);
    end
    valid = 1'b0;
    tick();
    check("done_pulse", md_done, 0);
  endtask

  initial begin
    logic [4:0]  e;
    logic [31:0] prev;
    int          seen;

    // reset state
    #3;
    check("rst_result", md_result, 0);
    check("rst_done", md_done, 0);
    check("rst_stall", stall, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // directed decode corners
    aluop = 3'b001; f7 = 7'h00; f3 = 3'd2; opcode = 1'b0; #1; check("lw_add", alu_sel, 0);
    opcode = 1'b1; #1; check("slti", alu_sel, 4);
    f3 = 3'd5; f7 = 7'h20; #1; check("srai", alu_sel, 8);
    f7 = 7'h00; #1; check("srli", alu_sel, 9);
    aluop = 3'b000; f7 = 7'h20; f3 = 3'd2; #1; check("unlisted", alu_sel, 0);
    aluop = 3'b011; f7 = 7'h00; f3 = 3'd4; #1; check("jal", alu_sel, 0);

    // randomised decode sweep; valid held only for non-M decodes
    for (int i = 0; i < 80; i++) begin
      case ($urandom % 4)
        0: aluop = 3'b000; 1: aluop = 3'b001; 2: aluop = 3'b011; default: aluop = 3'($urandom);
      endcase
      case ($urandom % 4)
        0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01; default: f7 = 7'($urandom);
      endcase
      f3 = 3'($urandom); opcode = 1'($urandom);
      e = dec_ref(aluop, f7, f3, opcode);
      valid = ~e[4];
      #1;
      check("dec_sel", alu_sel, e[3:0]);
      check("dec_mdop", md_op, e[4]);
      if (!e[4]) check("dec_stall", stall, 0);
      valid = 1'b0;
      tick();
    end
    opcode = 1'b0;

    // directed M ops, issued back to back
    run_md(3'd0, 32'hFFFF_FFFD, 32'd7);
    run_md(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_md(3'd5, 32'd100, 32'd7);
    run_md(3'd7, 32'd100, 32'd7);
    run_md(3'd4, 32'd5, 32'd0);
    run_md(3'd7, 32'd5, 32'd0);
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // random M ops
    for (int i = 0; i < 30; i++) run_md(3'($urandom), pick(), pick());

    // flush at RUN cycle 10
    prev = md_result;
    aluop = 3'b000; f7 = 7'h01; f3 = 3'd0; rs1 = 32'h1234; rs2 = 32'h99; valid = 1'b1;
    repeat (10) tick();
    check("run_stall", stall, 1);
    flush = 1'b1;
    tick();
    check("flush_stall", stall, 0);
    flush = 1'b0; valid = 1'b0;
    seen = 0;
    repeat (40) begin tick(); if (md_done) seen++; end
    check("flush_no_done", seen, 0);
    check("flush_result_kept", md_result, prev);

    // flush together with acceptance
    valid = 1'b1; flush = 1'b1; f3 = 3'd1;
    #1; check("flush_accept_stall", stall, 0);
    tick();
    valid = 1'b0; flush = 1'b0;
    #1; check("flush_accept_idle", stall, 0);
    tick(); check("flush_accept_done", md_done, 0);

    // asynchronous reset mid-RUN
    run_md(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    valid = 1'b1; f3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
    repeat (5) tick();
    #2; rst_n = 1'b0;
    #1;
    check("arst_result", md_result, 0);
    check("arst_done", md_done, 0);
    check("arst_stall", stall, 0);
    valid = 1'b0;
    tick(); rst_n = 1'b1; tick();
    check("post_rst_stall", stall, 0);

    // divide-disabled build corner (model follows the build)
    run_md(3'd5, 32'd100, 32'd7);
    run_md(3'd0, 32'hFFFF_FFFD, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
